// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side bus controller.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        INHIBIT,
        RTS,
        TX,
        ACK,
        RELEASE
    } ps2_host_state_t;

    localparam int unsigned PS2_TX_LAST_BIT = 9;
    localparam int unsigned PS2_PARITY_BIT  = 8;
    localparam int unsigned PS2_BIT_IDX_W   = 4;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data pads plus a registered
// falling-edge pulse on the synchronized clock.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic fall
);

    logic clk_meta;
    logic data_meta;
    logic clk_prev;

    // Idle bus level is high, so everything resets to 1 except the edge pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta  <= 1'b1;
            data_meta <= 1'b1;
            clk_sync  <= 1'b1;
            data_sync <= 1'b1;
            clk_prev  <= 1'b1;
            fall      <= 1'b0;
        end else begin
            clk_meta  <= ps2_clk_in;
            data_meta <= ps2_data_in;
            clk_sync  <= clk_meta;
            data_sync <= data_meta;
            clk_prev  <= clk_sync;
            fall      <= clk_prev & ~clk_sync;
        end
    end

endmodule

// File: rtl/ps2_host_ctrl.sv
// Arbitrates the open-drain PS/2 lines between device-to-host reception and
// host-to-device command frames (inhibit, request-to-send, shift, ACK check).
module ps2_host_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES    = 2500,
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       read_enable,
    output logic       cmd_done,
    output logic       cmd_ack,
    output logic       cmd_timeout
);

    localparam int unsigned CNT_MAX_A = (IDLE_CYCLES > INHIBIT_CYCLES) ? IDLE_CYCLES : INHIBIT_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] IDLE_LAST    = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic clk_sync;
    logic data_sync;
    logic fall;

    ps2_sync_edge u_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_sync    (clk_sync),
        .data_sync   (data_sync),
        .fall        (fall)
    );

    ps2_host_state_t            state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PS2_BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [7:0]                 byte_q, byte_d;
    logic                       parity_q, parity_d;
    logic                       ack_seen_q, ack_seen_d;
    logic                       done_ev, tmo_ev, wd_expired, frame_bit;
    logic                       clk_oe_d, data_oe_d, read_en_d, ready_d;
    logic                       done_d, ack_d, tmo_d;

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            byte_q      <= '0;
            parity_q    <= 1'b0;
            ack_seen_q  <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            read_enable <= 1'b1;
            cmd_ready   <= 1'b1;
            cmd_done    <= 1'b0;
            cmd_ack     <= 1'b0;
            cmd_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_q      <= byte_d;
            parity_q    <= parity_d;
            ack_seen_q  <= ack_seen_d;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
            read_enable <= read_en_d;
            cmd_ready   <= ready_d;
            cmd_done    <= done_d;
            cmd_ack     <= ack_d;
            cmd_timeout <= tmo_d;
        end
    end

    // Next-state and datapath; one counter serves idle, inhibit and watchdog.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_d     = byte_q;
        parity_d   = parity_q;
        ack_seen_d = ack_seen_q;
        done_ev    = 1'b0;
        tmo_ev     = 1'b0;
        wd_expired = ((state_q == TX) || (state_q == ACK) || (state_q == RELEASE))
                     && (cnt_q == TIMEOUT_LAST);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cmd_valid && cmd_ready) begin
                    byte_d   = cmd_data;
                    parity_d = ~^cmd_data;
                    state_d  = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!clk_sync) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    cnt_d   = '0;
                    state_d = INHIBIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RTS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RTS: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                state_d   = TX;
            end
            TX: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fall) begin
                    bit_idx_d = bit_idx_q + PS2_BIT_IDX_W'(1);
                    if (bit_idx_q == PS2_BIT_IDX_W'(PS2_TX_LAST_BIT)) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fall) begin
                    ack_seen_d = ~data_sync;
                    state_d    = RELEASE;
                end
            end
            RELEASE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (clk_sync && data_sync) begin
                    cnt_d   = '0;
                    done_ev = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Expiry overrides any same-cycle clock edge.
        if (wd_expired) begin
            cnt_d   = '0;
            done_ev = 1'b1;
            tmo_ev  = 1'b1;
            state_d = IDLE;
        end
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        read_en_d = 1'b0;
        ready_d   = 1'b0;
        done_d    = done_ev;
        ack_d     = cmd_ack;
        tmo_d     = cmd_timeout;
        frame_bit = 1'b1;

        if (bit_idx_q < PS2_BIT_IDX_W'(PS2_PARITY_BIT)) begin
            frame_bit = byte_q[bit_idx_q[2:0]];
        end else if (bit_idx_q == PS2_BIT_IDX_W'(PS2_PARITY_BIT)) begin
            frame_bit = parity_q;
        end

        if (done_ev) begin
            ack_d = ack_seen_q & ~tmo_ev;
            tmo_d = tmo_ev;
        end

        case (state_d)
            IDLE: begin
                read_en_d = 1'b1;
                ready_d   = 1'b1;
            end
            WAIT_IDLE: read_en_d = 1'b1;
            INHIBIT:   clk_oe_d  = 1'b1;
            RTS: begin
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b1;
            end
            // Start bit stays driven from RTS until the first device fall.
            TX:        data_oe_d = ((state_q == TX) && fall) ? ~frame_bit : ps2_data_oe;
            default:   data_oe_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl with an open-drain bus and a device model.
`timescale 1ns/1ps
module tb_ps2_host_ctrl;
    import ps2_pkg::*;

    localparam int unsigned IDLE_CYCLES    = 8;
    localparam int unsigned INHIBIT_CYCLES = 20;
    localparam int unsigned TIMEOUT_CYCLES = 4000;
    localparam int unsigned HALF           = 30;

    typedef struct packed {
        logic ack;
        logic tmo;
    } res_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, read_enable, cmd_done, cmd_ack, cmd_timeout;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc = 0;
    int unsigned accept_cyc = 0, rel_cyc = 0, done_cyc = 0;
    logic        watch = 1'b0, interfered = 1'b0;
    logic        exp_bits[$];
    res_t        exp_res[$];

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_ctrl #(
        .IDLE_CYCLES    (IDLE_CYCLES),
        .INHIBIT_CYCLES (INHIBIT_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .read_enable (read_enable),
        .cmd_done    (cmd_done),
        .cmd_ack     (cmd_ack),
        .cmd_timeout (cmd_timeout)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2) == 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (watch && (ps2_clk_oe || ps2_data_oe || !read_enable)) interfered = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) step();
    endtask

    // Queue a command and push its expected frame bits and result.
    task automatic issue_cmd(input logic [7:0] b, input logic exp_ack, input logic exp_tmo,
                             input logic push_bits);
        res_t r;
        check1("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_data  = b;
        cmd_valid = 1'b1;
        step();
        accept_cyc = cyc;
        cmd_valid  = 1'b0;
        cmd_data   = ~b;
        check1("cmd_ready_busy", cmd_ready, 1'b0);
        if (push_bits) begin
            for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
            exp_bits.push_back(odd_par(b));
            exp_bits.push_back(1'b1);
        end
        r.ack = exp_ack;
        r.tmo = exp_tmo;
        exp_res.push_back(r);
    endtask

    // Device side: see inhibit, then the clock release with the start bit low.
    task automatic wait_rts(input logic check_lat);
        int n = 0;
        while (ps2_clk_line && n < 3000) begin step(); n++; end
        check1("inhibit_seen", ps2_clk_line, 1'b0);
        n = 0;
        while (!ps2_clk_line && n < 3000) begin step(); n++; end
        check1("clk_released", ps2_clk_line, 1'b1);
        rel_cyc = cyc;
        if (check_lat) check32("claim_latency", rel_cyc - accept_cyc, IDLE_CYCLES + INHIBIT_CYCLES + 1);
        check1("start_bit", ps2_data_line, 1'b0);
    endtask

    // Device clocks a host frame in, sampling on rising edges; stops early with
    // the clock held low when abort_fall matches.
    task automatic dev_rx(input logic do_ack, input int abort_fall);
        logic b;
        wait_cyc(10);
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            wait_cyc(HALF);
            if (k == abort_fall) return;
            dev_clk_low = 1'b0;
            if (k <= 10) begin
                check32("exp_bits_avail", exp_bits.size() > 0, 1);
                if (exp_bits.size() > 0) begin
                    b = exp_bits.pop_front();
                    check1($sformatf("frame_bit%0d", k - 1), ps2_data_line, b);
                end
            end
            if (k == 10 && do_ack) begin
                wait_cyc(HALF - 5);
                dev_data_low = 1'b1;
                wait_cyc(5);
            end else if (k < 11) begin
                wait_cyc(HALF);
            end
        end
        dev_data_low = 1'b0;
    endtask

    // Device sends a byte to the host; a command is queued mid-frame. High
    // phases are kept shorter than the idle threshold.
    task automatic dev_tx_with_cmd(input logic [7:0] b, input logic [7:0] cmd);
        logic [10:0] frame;
        int n;
        frame = {1'b1, odd_par(b), b, 1'b0};
        watch = 1'b1;
        interfered = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            dev_data_low = ~frame[i];
            wait_cyc(3);
            dev_clk_low = 1'b1;
            wait_cyc(2);
            check1($sformatf("rx_bit%0d", i), ps2_data_line, frame[i]);
            if (i == 1) begin
                issue_cmd(cmd, 1'b1, 1'b0, 1'b1);
                wait_cyc(51);
            end else begin
                wait_cyc(52);
            end
            dev_clk_low = 1'b0;
            if (i < 10) wait_cyc(3);
        end
        watch = 1'b0;
        check1("rx_no_interference", interfered, 1'b0);
        n = 0;
        while (!ps2_clk_oe && n < 100) begin step(); n++; end
        check32("idle_claim_delay", n, IDLE_CYCLES + 2);
    endtask

    // Pop the expected result when cmd_done pulses.
    task automatic wait_done(input int max_cyc);
        res_t r;
        int n = 0;
        while (!cmd_done && n < max_cyc) begin step(); n++; end
        check1("done_seen", cmd_done, 1'b1);
        if (cmd_done) begin
            done_cyc = cyc;
            check1("done_clk_oe", ps2_clk_oe, 1'b0);
            check1("done_data_oe", ps2_data_oe, 1'b0);
            check32("exp_res_avail", exp_res.size() > 0, 1);
            if (exp_res.size() > 0) begin
                r = exp_res.pop_front();
                check1("cmd_ack", cmd_ack, r.ack);
                check1("cmd_timeout", cmd_timeout, r.tmo);
            end
            step();
            check1("done_single_pulse", cmd_done, 1'b0);
            check1("read_enable_back", read_enable, 1'b1);
        end
    endtask

    initial begin
        logic saw;
        wait_cyc(3);
        check1("rst_clk_oe", ps2_clk_oe, 1'b0);
        check1("rst_data_oe", ps2_data_oe, 1'b0);
        check1("rst_read_enable", read_enable, 1'b1);
        check1("rst_cmd_ready", cmd_ready, 1'b1);
        check1("rst_cmd_done", cmd_done, 1'b0);
        check1("rst_cmd_ack", cmd_ack, 1'b0);
        check1("rst_cmd_timeout", cmd_timeout, 1'b0);
        reset_n = 1'b1;
        wait_cyc(5);

        issue_cmd(8'hFF, 1'b1, 1'b0, 1'b1);
        wait_rts(1'b1);
        dev_rx(1'b1, 0);
        wait_done(100);

        issue_cmd(8'hED, 1'b0, 1'b0, 1'b1);
        check1("ack_holds", cmd_ack, 1'b1);
        wait_rts(1'b1);
        dev_rx(1'b0, 0);
        wait_done(100);

        wait_cyc(20);
        dev_tx_with_cmd(8'hAA, 8'h5A);
        wait_rts(1'b0);
        dev_rx(1'b1, 0);
        wait_done(100);

        issue_cmd(8'h3C, 1'b0, 1'b1, 1'b0);
        wait_rts(1'b1);
        wait_done(TIMEOUT_CYCLES + 100);
        check32("timeout_latency", done_cyc - rel_cyc, TIMEOUT_CYCLES);

        issue_cmd(8'hE6, 1'b0, 1'b0, 1'b1);
        wait_rts(1'b1);
        dev_rx(1'b1, 5);
        check1("bit4_driven_low", ps2_data_oe, 1'b1);
        reset_n = 1'b0;
        #1;
        check1("abort_clk_oe", ps2_clk_oe, 1'b0);
        check1("abort_data_oe", ps2_data_oe, 1'b0);
        dev_clk_low = 1'b0;
        exp_bits.delete();
        exp_res.delete();
        wait_cyc(3);
        reset_n = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            step();
            if (cmd_done) saw = 1'b1;
        end
        check1("no_done_after_abort", saw, 1'b0);
        check32("abort_state_idle", 32'(dut.state_q), 32'(IDLE));
        check1("abort_cmd_ready", cmd_ready, 1'b1);

        issue_cmd(8'h01, 1'b1, 1'b0, 1'b1);
        wait_rts(1'b1);
        dev_rx(1'b1, 0);
        wait_done(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: observed no end of run, required finish before 1 ms");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/ps2_host_ctrl.md
# ps2_host_ctrl

Sequences ownership of the bidirectional PS/2 clock and data lines between device-to-host reception and host-to-device command transmission. Sits between the open-drain pad drivers and the PS/2 receive block. While idle it releases both lines and enables the receiver. When a command byte is queued, it waits for bus idle, inhibits the device, performs request-to-send, and shifts out the frame on device-generated clocks. It then checks the device ACK and hands the bus back to the receiver.

## Interface
Parameters:
- IDLE_CYCLES, 2500: clk cycles ps2 clock must be continuously high before the bus may be claimed (50 us @ 50 MHz).
- INHIBIT_CYCLES, 5000: clk cycles the clock line is held low during inhibit (100 us @ 50 MHz).
- TIMEOUT_CYCLES, 750000: max clk cycles from RTS release to ACK-phase completion (15 ms @ 50 MHz).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ps2_clk_in  in  1  raw PS/2 clock pad value (asynchronous)
- ps2_data_in  in  1  raw PS/2 data pad value (asynchronous)
- ps2_clk_oe  out  1  1 = pull clock line low; 0 = release
- ps2_data_oe  out  1  1 = pull data line low; 0 = release
- cmd_data  in  8  command byte
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- read_enable  out  1  enables the PS/2 receiver
- cmd_done  out  1  one-cycle pulse at transaction end
- cmd_ack  out  1  valid with cmd_done; 1 = device ACK seen (data low at ACK edge)
- cmd_timeout  out  1  valid with cmd_done; 1 = watchdog expired

## Operation
- Inputs pass through a 2-flop synchronizer. A falling-edge pulse `fall` is asserted for one cycle when the synced clock goes 1→0.
- States and transitions:
  - IDLE: lines released, read_enable=1, cmd_ready=1. On accept: latch byte, compute parity = ~^cmd_data (odd), go to WAIT_IDLE.
  - WAIT_IDLE: read_enable=1. The counter increments while synced clock is high and clears to 0 when it is low. At IDLE_CYCLES go to INHIBIT.
  - INHIBIT: read_enable=0, ps2_clk_oe=1, for INHIBIT_CYCLES, then go to RTS.
  - RTS: ps2_data_oe=1 (start bit 0) with ps2_clk_oe still 1 for exactly 1 cycle. Then release the clock, zero the watchdog, bit_idx=0, go to TX.
  - TX: on each `fall`, drive frame bit bit_idx (0–7 data LSB first, 8 parity, 9 stop = released), then bit_idx++. ps2_data_oe = ~bit. After bit 9 is driven, go to ACK.
  - ACK: on next `fall`, sample synced data; cmd_ack = ~data. Go to RELEASE.
  - RELEASE: wait until synced clock and data are both high, then pulse cmd_done and go to IDLE.
- Watchdog runs in TX, ACK and RELEASE. On reaching TIMEOUT_CYCLES: release both lines, pulse cmd_done with cmd_timeout=1 and cmd_ack=0, go to IDLE.
- The command byte is captured at accept; later changes on cmd_data are ignored.

## Timing
- Reset values: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, read_enable=1, cmd_ready=1, cmd_done=0, cmd_ack=0, cmd_timeout=0, all counters 0.
- cmd_ready is 1 only in IDLE. A new command is accepted no earlier than the cycle after cmd_done.
- Synchronizer latency is 2 clk. `fall` is asserted 3 clk after the pad edge. ps2_data_oe updates 1 clk after `fall`.
- Minimum command latency from accept to clock release is IDLE_CYCLES + INHIBIT_CYCLES + 1 clk.
- A clock-low glitch during WAIT_IDLE restarts the idle count. It must never skip ahead.
- In INHIBIT and RTS, `fall` pulses are ignored because the host is driving the clock.
- If `fall` and watchdog expiry coincide, the timeout wins.
- cmd_ack and cmd_timeout hold their values until the next cmd_done.
- reset_n asserted mid-transaction releases both lines immediately (asynchronously) and aborts with no cmd_done.

## Structure
- Package ps2_pkg holds:
  - state enum ps2_host_state_t {IDLE, WAIT_IDLE, INHIBIT, RTS, TX, ACK, RELEASE};
  - constants PS2_TX_LAST_BIT=9 and PS2_PARITY_BIT=8.
- Sub-module ps2_sync_edge contains the 2-flop synchronizer for clock and data plus the falling-edge detector. It takes clk and reset_n, and resets its flops to 1.

## Test plan
Run with IDLE_CYCLES=8, INHIBIT_CYCLES=20, TIMEOUT_CYCLES=4000, and a device model clocking at a 60-clk period.
- cmd 0xFF, device ACKs:
  - device samples frame bits 0,1×8, parity 1, stop 1;
  - cmd_done pulses once with cmd_ack=1 and cmd_timeout=0;
  - read_enable returns to 1.
- cmd 0xED, device NACKs (data high at ACK):
  - device sees parity 1 (bits 10110111 have six ones);
  - result is cmd_ack=0, cmd_timeout=0.
- cmd_valid while the device sends 0xAA:
  - INHIBIT is not entered until 8 consecutive high clk cycles after the device's last edge;
  - the receiver packet completes intact.
- Device never clocks after RTS: cmd_done with cmd_timeout=1 exactly 4000 clk after clock release, and both oe signals = 0.
- reset_n pulled low during TX bit 4: ps2_clk_oe and ps2_data_oe are 0 within the same cycle, state is IDLE after release, and cmd_ready=1.
